// File: rtl/bist_pkg.sv
// Shared types and March C- element tables for the BIST sequencer.
// Table bit i describes element Mi.
package bist_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_OP1,
    S_OP2,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam int NUM_ELEM     = 6;
  localparam int MAX_READ_LAT = 4;

  // Up-counting elements: M0..M2.
  localparam logic [NUM_ELEM-1:0] ELEM_UP     = 6'b000111;
  // Elements with a read followed by a write: M1..M4.
  localparam logic [NUM_ELEM-1:0] ELEM_TWO_OP = 6'b011110;
  // First operation is a read everywhere except M0.
  localparam logic [NUM_ELEM-1:0] OP1_READ    = 6'b111110;
  // Data value of the first op (w0, r0, r1, r0, r1, r0).
  localparam logic [NUM_ELEM-1:0] OP1_DATA    = 6'b010100;
  // Data value of the second op (M1 w1, M2 w0, M3 w1, M4 w0).
  localparam logic [NUM_ELEM-1:0] OP2_DATA    = 6'b001010;

endpackage

// File: rtl/bist_rd_cmp.sv
// Read-compare pipeline: delays each read's expectation by READ_LAT cycles,
// compares it against the returned data and latches the first mismatch.
module bist_rd_cmp
  import bist_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              push,
  input  logic              exp_bit,
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        elem,
  input  logic [DATA_W-1:0] rdata,
  output logic              first_mismatch,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem
);

  logic [READ_LAT-1:0] vld_q;
  logic [READ_LAT-1:0] exp_q;
  logic [ADDR_W-1:0]   addr_q [READ_LAT];
  logic [2:0]          elem_q [READ_LAT];
  logic                mismatch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      exp_q <= '0;
      for (int i = 0; i < READ_LAT; i++) begin
        addr_q[i] <= '0;
        elem_q[i] <= '0;
      end
    end else begin
      vld_q[0]  <= push;
      exp_q[0]  <= exp_bit;
      addr_q[0] <= addr;
      elem_q[0] <= elem;
      for (int i = 1; i < READ_LAT; i++) begin
        vld_q[i]  <= vld_q[i-1];
        exp_q[i]  <= exp_q[i-1];
        addr_q[i] <= addr_q[i-1];
        elem_q[i] <= elem_q[i-1];
      end
    end
  end

  assign mismatch       = vld_q[READ_LAT-1] &&
                          (rdata != {DATA_W{exp_q[READ_LAT-1]}});
  assign first_mismatch = mismatch && !fail;

  // Only the first mismatch of a run is recorded; later ones leave it intact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_elem <= '0;
    end else if (clear) begin
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_elem <= '0;
    end else if (first_mismatch) begin
      fail      <= 1'b1;
      fail_addr <= addr_q[READ_LAT-1];
      fail_elem <= elem_q[READ_LAT-1];
    end
  end

endmodule

// File: rtl/march_cm_ctrl.sv
// March C- BIST sequencer driving an address generator and a memory port.
// Optional macro BIST_STOP_ON_FAIL_EN: end the test at the first mismatch.
module march_cm_ctrl
  import bist_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              gen_rst,
  output logic              gen_preset,
  output logic              gen_en,
  output logic              gen_up,
  input  logic [ADDR_W-1:0] gen_addr,
  input  logic              gen_last,
  output logic              mem_we,
  output logic              mem_re,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem
);

  localparam int                DRAIN_W    = $clog2(MAX_READ_LAT);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(READ_LAT - 1);
  localparam logic [2:0]        LAST_ELEM  = 3'(NUM_ELEM - 1);

  state_t               state, next_state;
  logic [2:0]           elem_q, elem_d;
  logic                 at_last_q, at_last_d;
  logic [DRAIN_W-1:0]   drain_q, drain_d;
  logic                 done_q, done_d;
  logic                 rd_push, rd_exp, rd_clear;
  logic                 first_mismatch, stop_now, last_op;

`ifdef BIST_STOP_ON_FAIL_EN
  assign stop_now = first_mismatch;
`else
  assign stop_now = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      elem_q    <= '0;
      at_last_q <= 1'b0;
      drain_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state     <= next_state;
      elem_q    <= elem_d;
      at_last_q <= at_last_d;
      drain_q   <= drain_d;
      done_q    <= done_d;
    end
  end

  // at_last marks the sweep's final address: its last op must not step the generator.
  always_comb begin
    next_state = state;
    elem_d     = elem_q;
    at_last_d  = at_last_q;
    drain_d    = '0;
    done_d     = done_q;
    gen_rst    = 1'b0;
    gen_preset = 1'b0;
    gen_en     = 1'b0;
    gen_up     = 1'b0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    mem_wdata  = '0;
    rd_push    = 1'b0;
    rd_exp     = 1'b0;
    rd_clear   = 1'b0;
    last_op    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          next_state = S_SETUP;
          elem_d     = '0;
          done_d     = 1'b0;
          rd_clear   = 1'b1;
        end
      end
      S_SETUP: begin
        gen_up     = ELEM_UP[elem_q];
        gen_rst    = ELEM_UP[elem_q];
        gen_preset = !ELEM_UP[elem_q];
        at_last_d  = 1'b0;
        next_state = S_OP1;
      end
      S_OP1, S_OP2: begin
        gen_up = ELEM_UP[elem_q];
        if (stop_now) begin
          next_state = S_DRAIN;
        end else begin
          if (state == S_OP1) begin
            if (OP1_READ[elem_q]) begin
              mem_re  = 1'b1;
              rd_push = 1'b1;
              rd_exp  = OP1_DATA[elem_q];
            end else begin
              mem_we    = 1'b1;
              mem_wdata = {DATA_W{OP1_DATA[elem_q]}};
            end
            last_op = !ELEM_TWO_OP[elem_q];
            if (ELEM_TWO_OP[elem_q]) next_state = S_OP2;
          end else begin
            mem_we    = 1'b1;
            mem_wdata = {DATA_W{OP2_DATA[elem_q]}};
            last_op   = 1'b1;
          end
          if (last_op) begin
            if (at_last_q) begin
              if (elem_q == LAST_ELEM) begin
                next_state = S_DRAIN;
              end else begin
                elem_d     = elem_q + 3'd1;
                next_state = S_SETUP;
              end
            end else begin
              gen_en     = 1'b1;
              at_last_d  = gen_last;
              next_state = S_OP1;
            end
          end
        end
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          next_state = S_DONE;
          done_d     = 1'b1;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      S_DONE: begin
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  assign busy = (state != S_IDLE) && (state != S_DONE);
  assign done = done_q;

  bist_rd_cmp #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .READ_LAT (READ_LAT)
  ) u_rd_cmp (
    .clk            (clk),
    .rst_n          (rst_n),
    .clear          (rd_clear),
    .push           (rd_push),
    .exp_bit        (rd_exp),
    .addr           (gen_addr),
    .elem           (elem_q),
    .rdata          (mem_rdata),
    .first_mismatch (first_mismatch),
    .fail           (fail),
    .fail_addr      (fail_addr),
    .fail_elem      (fail_elem)
  );

endmodule

// File: tb/tb_march_cm_ctrl.sv
// Bench for march_cm_ctrl: two instances (READ_LAT 1 and 3), each with a generator
// and a fault-injectable memory, checked against a March C- operation-list model.
`timescale 1ns/1ps
module tb_march_cm_ctrl;

  localparam int AW = 2;
  localparam int DW = 8;
  localparam int N  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start_s [2];
  logic          gen_rst_s [2];
  logic          gen_preset_s [2];
  logic          gen_en_s [2];
  logic          gen_up_s [2];
  logic          gen_last_s [2];
  logic [AW-1:0] gaddr [2];
  logic          we_s [2];
  logic          re_s [2];
  logic [DW-1:0] wdata_s [2];
  logic [DW-1:0] rdata_s [2];
  logic          busy_s [2];
  logic          done_s [2];
  logic          fail_s [2];
  logic [AW-1:0] faddr_s [2];
  logic [2:0]    felem_s [2];

  logic [DW-1:0] mem [2][N];
  logic [DW-1:0] rpipe [2][4];
  int            ft [2];
  int            fa [2];
  int            fb [2];

  int nCheck = 0;
  int nPass  = 0;

  march_cm_ctrl #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]),
    .gen_rst(gen_rst_s[0]), .gen_preset(gen_preset_s[0]), .gen_en(gen_en_s[0]),
    .gen_up(gen_up_s[0]), .gen_addr(gaddr[0]), .gen_last(gen_last_s[0]),
    .mem_we(we_s[0]), .mem_re(re_s[0]), .mem_wdata(wdata_s[0]), .mem_rdata(rdata_s[0]),
    .busy(busy_s[0]), .done(done_s[0]), .fail(fail_s[0]),
    .fail_addr(faddr_s[0]), .fail_elem(felem_s[0])
  );

  march_cm_ctrl #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]),
    .gen_rst(gen_rst_s[1]), .gen_preset(gen_preset_s[1]), .gen_en(gen_en_s[1]),
    .gen_up(gen_up_s[1]), .gen_addr(gaddr[1]), .gen_last(gen_last_s[1]),
    .mem_we(we_s[1]), .mem_re(re_s[1]), .mem_wdata(wdata_s[1]), .mem_rdata(rdata_s[1]),
    .busy(busy_s[1]), .done(done_s[1]), .fail(fail_s[1]),
    .fail_addr(faddr_s[1]), .fail_elem(felem_s[1])
  );

  assign rdata_s[0]    = rpipe[0][0];
  assign rdata_s[1]    = rpipe[1][2];
  assign gen_last_s[0] = gen_up_s[0] ? (gaddr[0] == 2'd2) : (gaddr[0] == 2'd1);
  assign gen_last_s[1] = gen_up_s[1] ? (gaddr[1] == 2'd2) : (gaddr[1] == 2'd1);

  // Fault kinds: 1 stuck-at-0, 2 stuck-at-1, 3 cannot fall 1->0, 4 cannot rise 0->1.
  function automatic logic [DW-1:0] faultWrite(int kind, int faddr, int fbit, int a,
                                               logic [DW-1:0] old, logic [DW-1:0] d);
    logic [DW-1:0] r;
    r = d;
    if (a == faddr) begin
      case (kind)
        1: r[fbit] = 1'b0;
        2: r[fbit] = 1'b1;
        3: r[fbit] = old[fbit] | d[fbit];
        4: r[fbit] = old[fbit] & d[fbit];
        default: r = d;
      endcase
    end
    return r;
  endfunction

  function automatic int encOp(bit we, int a, logic [DW-1:0] d);
    return (we ? 1024 : 2048) + a * 256 + int'(d);
  endfunction

  // Generator and memory environment for both instances.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (gen_rst_s[k])         gaddr[k] <= '0;
      else if (gen_preset_s[k]) gaddr[k] <= '1;
      else if (gen_en_s[k])     gaddr[k] <= gen_up_s[k] ? gaddr[k] + 2'd1 : gaddr[k] - 2'd1;
      if (start_s[k] && !busy_s[k]) begin
        for (int i = 0; i < N; i++) mem[k][i] <= '0;
      end else if (we_s[k]) begin
        mem[k][gaddr[k]] <= faultWrite(ft[k], fa[k], fb[k], int'(gaddr[k]),
                                       mem[k][gaddr[k]], wdata_s[k]);
      end
      for (int j = 3; j > 0; j--) rpipe[k][j] <= rpipe[k][j-1];
      rpipe[k][0] <= re_s[k] ? mem[k][gaddr[k]] : 8'h5A;
    end
  end

  // Monitor of the selected instance.
  int sel = 0;
  bit monOn = 1'b0;
  int busyCnt, bothCnt, lastStrobeCyc;
  int obsQ[$];
  always @(negedge clk) begin
    if (monOn) begin
      if (busy_s[sel]) busyCnt++;
      if (we_s[sel] && re_s[sel]) bothCnt++;
      if (we_s[sel] || re_s[sel]) begin
        obsQ.push_back(encOp(we_s[sel], int'(gaddr[sel]), we_s[sel] ? wdata_s[sel] : '0));
        lastStrobeCyc = busyCnt;
      end
    end
  end

  // Reference model: walk the March C- element list over a faulty memory.
  string march [6] = '{"w0", "r0w1", "r1w0", "r0w1", "r1w0", "r0"};
  bit    elemUp [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  int    expQ[$];
  int    expFail, expFaddr, expFelem;

  task automatic buildModel(input int mft, input int mfa, input int mfb);
    logic [DW-1:0] m [N];
    expQ.delete();
    expFail = 0; expFaddr = 0; expFelem = 0;
    for (int i = 0; i < N; i++) m[i] = '0;
    for (int e = 0; e < 6; e++) begin
      for (int n = 0; n < N; n++) begin
        int a;
        string s;
        a = elemUp[e] ? n : N - 1 - n;
        s = march[e];
        for (int o = 0; o < s.len(); o += 2) begin
          logic [DW-1:0] v;
          v = (s[o+1] == "1") ? '1 : '0;
          if (s[o] == "r") begin
            expQ.push_back(encOp(1'b0, a, '0));
            if (m[a] != v && expFail == 0) begin
              expFail = 1; expFaddr = a; expFelem = e;
            end
          end else begin
            expQ.push_back(encOp(1'b1, a, v));
            m[a] = faultWrite(mft, mfa, mfb, a, m[a], v);
          end
        end
      end
    end
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    nCheck++;
    if (observed == expected) nPass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
  endtask

  task automatic applyStimulus(input int k, input int mft, input int mfa, input int mfb,
                               input bit noise);
    int cyc, full, rl, mism, lim;
    rl   = (k == 0) ? 1 : 3;
    full = 6 + 10 * N + rl;
    ft[k] = mft; fa[k] = mfa; fb[k] = mfb;
    buildModel(mft, mfa, mfb);
    @(negedge clk);
    sel = k; obsQ.delete(); busyCnt = 0; bothCnt = 0; lastStrobeCyc = 0; monOn = 1'b1;
    start_s[k] = 1'b1;
    @(negedge clk);
    start_s[k] = 1'b0;
    checkOutput("clear_on_start", int'({done_s[k], fail_s[k]}), 0);
    cyc = 0;
    while (!done_s[k] && cyc < 2000) begin
      start_s[k] = noise && busy_s[k] && ($urandom_range(0, 3) == 0);
      @(negedge clk);
      cyc++;
    end
    start_s[k] = 1'b0;
    monOn = 1'b0;
    checkOutput("done_timeout", int'(cyc < 2000), 1);
    checkOutput("done", int'(done_s[k]), 1);
    checkOutput("busy_low", int'(busy_s[k]), 0);
    checkOutput("fail", int'(fail_s[k]), expFail);
    checkOutput("fail_addr", int'(faddr_s[k]), expFaddr);
    checkOutput("fail_elem", int'(felem_s[k]), expFelem);
    checkOutput("we_re_overlap", bothCnt, 0);
    mism = 0;
    lim = (obsQ.size() < expQ.size()) ? obsQ.size() : expQ.size();
    for (int i = 0; i < lim; i++) if (obsQ[i] != expQ[i]) mism++;
    checkOutput("op_sequence", mism, 0);
`ifdef BIST_STOP_ON_FAIL_EN
    if (expFail != 0) begin
      checkOutput("early_end", int'(busyCnt < full), 1);
      checkOutput("quiet_drain", int'(lastStrobeCyc <= busyCnt - rl), 1);
    end else begin
      checkOutput("busy_cycles", busyCnt, full);
      checkOutput("op_count", obsQ.size(), expQ.size());
    end
`else
    checkOutput("busy_cycles", busyCnt, full);
    checkOutput("op_count", obsQ.size(), expQ.size());
`endif
  endtask

  task automatic resetMidTest();
    int cyc, sz;
    ft[0] = 0;
    @(negedge clk);
    sel = 0; obsQ.delete(); busyCnt = 0; bothCnt = 0; monOn = 1'b1;
    start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    cyc = 0;
    while (obsQ.size() < 22 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("reach_m3", int'(cyc < 500), 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_ctrl", int'({gen_rst_s[0], gen_preset_s[0], gen_en_s[0], gen_up_s[0],
                we_s[0], re_s[0], busy_s[0], done_s[0], fail_s[0]}), 0);
    checkOutput("async_rst_data", int'({wdata_s[0], faddr_s[0], felem_s[0]}), 0);
    sz = obsQ.size();
    repeat (3) @(negedge clk);
    checkOutput("no_strobes_in_rst", obsQ.size(), sz);
    monOn = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    start_s[0] = 1'b0; start_s[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin ft[k] = 0; fa[k] = 0; fb[k] = 0; end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_state", int'({busy_s[0], done_s[0], fail_s[0], we_s[0], re_s[0],
                gen_rst_s[0], gen_preset_s[0], gen_en_s[0], gen_up_s[0]}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(0, 0, 0, 0, 1'b0);
    applyStimulus(0, 1, 2, 0, 1'b0);
    applyStimulus(0, 3, 1, int'($urandom_range(0, 7)), 1'b0);
    applyStimulus(0, 0, 0, 0, 1'b0);
    applyStimulus(0, 0, 0, 0, 1'b1);
    applyStimulus(0, 1, 2, 0, 1'b1);
    resetMidTest();
    applyStimulus(0, 0, 0, 0, 1'b0);
    applyStimulus(1, 0, 0, 0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(int'($urandom_range(0, 1)), int'($urandom_range(0, 4)),
                    int'($urandom_range(0, N - 1)), int'($urandom_range(0, DW - 1)),
                    1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", nPass, nCheck);
    $finish;
  end

endmodule
